// File: rtl/systolic_feed_ctrl_if.sv
// Command/status bundle between the host sequencer and the systolic feed controller.
interface systolic_feed_ctrl_if #(
  parameter int ROWS       = 3,
  parameter int ADDR_WIDTH = 2
);
  logic                  i_start;
  logic [ADDR_WIDTH:0]   i_len;
  logic                  o_busy;
  logic                  o_acc_clr;
  logic [ROWS-1:0]       o_rd;
  logic [ROWS-1:0]       o_valid;
  logic                  o_done;

  modport master (
    output i_start, i_len,
    input  o_busy, o_acc_clr, o_rd, o_valid, o_done
  );

  modport slave (
    input  i_start, i_len,
    output o_busy, o_acc_clr, o_rd, o_valid, o_done
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequences the skewed per-row input-buffer reads that feed the systolic array.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a start with a non-zero length
//   S_CLEAR | one cycle, accumulator clear issued
//   S_FEED  | t = 0..len+ROWS-2, row r reads while r <= t < r+len
//   S_DRAIN | DRAIN_CYCLES cycles for partial sums to flush
//   S_DONE  | one cycle, completion; a new start here chains directly
//
// All outputs are decoded from the current state and then registered, so
// they trail the state register by one cycle and are glitch-free.
module systolic_feed_ctrl #(
  parameter int ROWS         = 3,
  parameter int ADDR_WIDTH   = 2,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  systolic_feed_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int TW    = ADDR_WIDTH + 4;
  localparam int DW    = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   len_q, len_nxt, len_sat;
  logic [TW-1:0]   t_q, t_nxt, t_last;
  logic [DW-1:0]   dcnt_q, dcnt_nxt;
  logic            accept;
  logic [ROWS-1:0] rd_dec;

  logic            busy_q;
  logic            acc_clr_q;
  logic            done_q;
  logic [ROWS-1:0] rd_q;
  logic [ROWS-1:0] valid_q;

  // Length clamp, last feed step and start qualification.
  always_comb begin
    len_sat = (bus.i_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.i_len;
    t_last  = TW'(len_q) + TW'(ROWS) - TW'(2);
    // DONE also accepts a start so back-to-back runs have no idle gap.
    accept  = bus.i_start && (bus.i_len != '0) &&
              ((state == S_IDLE) || (state == S_DONE));
  end

  // Next-state and counter update.
  always_comb begin
    state_nxt = state;
    t_nxt     = t_q;
    dcnt_nxt  = dcnt_q;
    len_nxt   = len_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_CLEAR;
          len_nxt   = len_sat;
        end
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
        t_nxt     = '0;
      end
      S_FEED: begin
        if (t_q == t_last) begin
          state_nxt = S_DRAIN;
          dcnt_nxt  = DW'(DRAIN_CYCLES - 1);
        end else begin
          t_nxt = t_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == '0) state_nxt = S_DONE;
        else              dcnt_nxt  = dcnt_q - DW'(1);
      end
      S_DONE: begin
        if (accept) begin
          state_nxt = S_CLEAR;
          len_nxt   = len_sat;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Diagonal skew: row r reads on feed steps r .. r+len-1.
  always_comb begin
    rd_dec = '0;
    for (int r = 0; r < ROWS; r++) begin
      rd_dec[r] = (state == S_FEED) && (t_q >= TW'(r)) &&
                  (t_q < TW'(r) + TW'(len_q));
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      t_q    <= '0;
      dcnt_q <= '0;
      len_q  <= '0;
    end else begin
      state  <= state_nxt;
      t_q    <= t_nxt;
      dcnt_q <= dcnt_nxt;
      len_q  <= len_nxt;
    end
  end

  // Registered outputs; valid tracks the one-cycle buffer read latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= '0;
      valid_q   <= '0;
    end else begin
      busy_q    <= (state != S_IDLE);
      acc_clr_q <= (state == S_CLEAR);
      done_q    <= (state == S_DONE);
      rd_q      <= rd_dec;
      valid_q   <= rd_q;
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_acc_clr = acc_clr_q;
  assign bus.o_done    = done_q;
  assign bus.o_rd      = rd_q;
  assign bus.o_valid   = valid_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: expected per-cycle output records
// are queued when a start is issued and popped by a monitor on every active cycle.
module tb_systolic_feed_ctrl;

  localparam int ROWS  = 3;
  localparam int AW    = 2;
  localparam int DRAIN = 6;

  typedef struct packed {
    logic [31:0]     cyc;
    logic            busy;
    logic            acc;
    logic [ROWS-1:0] rd;
    logic [ROWS-1:0] valid;
    logic            done;
  } ev_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  systolic_feed_ctrl_if #(.ROWS(ROWS), .ADDR_WIDTH(AW)) bus ();

  systolic_feed_ctrl #(
    .ROWS(ROWS), .ADDR_WIDTH(AW), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  ev_t             exp_q[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              g0      = 0;
  int              last_done = -1;
  int              rd_cnt[ROWS];
  logic [ROWS-1:0] rd_log[0:31];

  logic [ROWS-1:0] tbl4[6] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100};
  logic [ROWS-1:0] tbl1[3] = '{3'b001, 3'b010, 3'b100};

  function automatic logic [ROWS-1:0] rd_model(int n, int eff);
    logic [ROWS-1:0] v;
    int t;
    v = '0;
    if (n >= 2 && n <= eff + ROWS) begin
      t = n - 2;
      for (int r = 0; r < ROWS; r++) v[r] = (t >= r) && (t < r + eff);
    end
    return v;
  endfunction

  task automatic push_run(int base, int eff, int upto);
    int total;
    ev_t e;
    total = eff + ROWS - 1 + DRAIN + 2;
    for (int n = 1; n <= total; n++) begin
      if (n <= upto) begin
        e.cyc   = base + n;
        e.busy  = 1'b1;
        e.acc   = (n == 1);
        e.rd    = rd_model(n, eff);
        e.valid = rd_model(n - 1, eff);
        e.done  = (n == total);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic monitor();
    ev_t  got, e;
    logic act;
    forever begin
      @(negedge i_clk);
      got.cyc   = cyc;
      got.busy  = bus.o_busy;
      got.acc   = bus.o_acc_clr;
      got.rd    = bus.o_rd;
      got.valid = bus.o_valid;
      got.done  = bus.o_done;
      if (bus.o_acc_clr === 1'b1)
        for (int r = 0; r < ROWS; r++) rd_cnt[r] = 0;
      for (int r = 0; r < ROWS; r++) if (bus.o_rd[r] === 1'b1) rd_cnt[r]++;
      if (cyc - g0 >= 0 && cyc - g0 < 32) rd_log[cyc - g0] = bus.o_rd;
      if (bus.o_done === 1'b1) last_done = cyc;
      act = bus.o_busy | bus.o_acc_clr | bus.o_done | (|bus.o_rd) | (|bus.o_valid);
      if (act !== 1'b0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: cyc %0d busy %b acc %b rd %b valid %b done %b, required no activity",
                   cyc, got.busy, got.acc, got.rd, got.valid, got.done);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL sb_event: got cyc %0d busy %b acc %b rd %b valid %b done %b; required cyc %0d busy %b acc %b rd %b valid %b done %b",
                     got.cyc, got.busy, got.acc, got.rd, got.valid, got.done,
                     e.cyc, e.busy, e.acc, e.rd, e.valid, e.done);
          end
        end
      end
    end
  endtask

  task automatic issue(logic [AW:0] len, int eff, int upto);
    @(negedge i_clk);
    bus.i_start = 1'b1;
    bus.i_len   = len;
    g0 = cyc + 1;
    last_done = -1;
    if (eff > 0) push_run(g0, eff, upto);
    @(negedge i_clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_rel(int k);
    while (cyc < g0 + k) @(negedge i_clk);
  endtask

  task automatic wait_empty(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge i_clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) @(negedge i_clk);
  endtask

  task automatic check_counts(string name, int expv);
    for (int r = 0; r < ROWS; r++) check(name, rd_cnt[r], expv);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_len   = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge i_clk);
    check("reset_outputs",
          {bus.o_busy, bus.o_acc_clr, bus.o_rd, bus.o_valid, bus.o_done}, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // len=4, default geometry
    issue(3'd4, 4, 99);
    wait_empty("t1_drain");
    check("t1_done_cycle", last_done - g0, 14);
    for (int i = 0; i < 6; i++) check("t1_rd_pattern", rd_log[2 + i], tbl4[i]);
    check_counts("t1_rd_count", 4);

    // len=1
    issue(3'd1, 1, 99);
    wait_empty("t2_drain");
    check("t2_done_cycle", last_done - g0, 11);
    for (int i = 0; i < 3; i++) check("t2_rd_pattern", rd_log[2 + i], tbl1[i]);
    check_counts("t2_rd_count", 1);

    // len=0 is ignored
    issue(3'd0, 0, 0);
    repeat (5) @(negedge i_clk);
    check("t3_len0_busy", bus.o_busy, 0);

    // start pulsed mid-FEED is ignored
    issue(3'd4, 4, 99);
    wait_rel(4);
    bus.i_start = 1'b1;
    bus.i_len   = 3'd1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    wait_empty("t4_drain");
    check("t4_done_cycle", last_done - g0, 14);
    check_counts("t4_rd_count", 4);

    // reset in cycle 5 aborts the run
    issue(3'd4, 4, 5);
    wait_rel(5);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("t5_rst_outputs",
          {bus.o_busy, bus.o_acc_clr, bus.o_rd, bus.o_valid, bus.o_done}, 0);
    check("t5_queue_empty", exp_q.size(), 0);
    i_rst = 1'b0;
    repeat (12) @(negedge i_clk);
    check("t5_no_done", last_done, -1);
    issue(3'd2, 2, 99);
    wait_empty("t5b_drain");
    check("t5b_done_cycle", last_done - g0, 12);
    check_counts("t5b_rd_count", 2);

    // len=7 saturates to DEPTH
    issue(3'd7, 4, 99);
    wait_empty("t6_drain");
    check("t6_done_cycle", last_done - g0, 14);
    for (int i = 0; i < 6; i++) check("t6_rd_pattern", rd_log[2 + i], tbl4[i]);
    check_counts("t6_rd_count", 4);

    // back to back with start held through DONE
    @(negedge i_clk);
    bus.i_start = 1'b1;
    bus.i_len   = 3'd4;
    g0 = cyc + 1;
    last_done = -1;
    push_run(g0, 4, 99);
    push_run(g0 + 14, 4, 99);
    wait_rel(16);
    bus.i_start = 1'b0;
    wait_empty("t7_drain");
    check("t7_done2_cycle", last_done - g0, 28);
    check_counts("t7_rd_count", 4);

    repeat (3) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
